// File: rtl/shift_wb_queue.sv
// Write-back queue between the shifter/ALU execute stage and the register-file write port.
// Buffers {data, rd} results, drains them in order when the port is free, and forwards queued values to decode.
module shift_wb_queue #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [REG_AW-1:0]        in_rd,
    input  logic                     rf_stall,
    output logic                     rf_we,
    output logic [REG_AW-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [REG_AW-1:0]        lookup_addr,
    output logic                     lookup_hit,
    output logic [DATA_W-1:0]        lookup_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [REG_AW-1:0] mem_rd   [DEPTH];
    logic              empty;
    logic              push;
    logic              pop;

    assign empty    = (count == '0);
    // Depends on count only, so a same-cycle pop cannot open the input.
    assign in_ready = (count != CNT_W'(DEPTH));
    // r0 writes complete the handshake but are never stored.
    assign push     = in_valid && in_ready && !flush && (in_rd != '0);
    // Reset held low abandons the queue without issuing a write.
    assign rf_we    = !empty && !rf_stall && !flush && rst_n;
    assign pop      = rf_we;

    assign rf_waddr = empty ? '0 : mem_rd[head];
    assign rf_wdata = empty ? '0 : mem_data[head];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[tail] <= in_data;
            mem_rd[tail]   <= in_rd;
        end
    end

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (lookup_addr != '0) &&
                (mem_rd[head + PTR_W'(i)] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = mem_data[head + PTR_W'(i)];
            end
        end
    end

endmodule
